pulse_sequencer: RTL and testbench

Burst controller that initiates the inter-pulse delay handshake and emits the light pulses. Per burst it raises `dl_launch` to the delay generator, waits for its `end_flg`, fires a light pulse of programmable width, releases `dl_launch` so the delay generator clears, and repeats for N pulses. It sits between the host/config logic (`start`, burst settings) and the delay generator (`dl_launch`/`delay_o`/`dl_mlt_o` out, `end_flg` in).

---
 rtl/pulse_seq_pkg.sv | 27 ++
 rtl/pulse_width_timer.sv | 35 +++
 rtl/pulse_sequencer.sv | 171 +++++++++++++++++
 tb/tb_pulse_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_seq_pkg.sv
// Shared definitions for the pulse sequencer slice.
//   state_t          : burst controller states
//   MLT_* constants  : delay multiplier codes carried on dl_mlt_o
//   mlt_factor()     : clock multiplier a delay generator applies for a code
package pulse_seq_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LAUNCH  = 3'd1,
        PULSE   = 3'd2,
        RECOVER = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [4:0] MLT_X1   = 5'd1;  // delay counted in single clocks
    localparam logic [4:0] MLT_X100 = 5'd2;  // delay counted in units of 100 clocks
    // Any other code means units of 100000 clocks.

    function automatic int unsigned mlt_factor(input logic [4:0] code);
        case (code)
            MLT_X1:   return 1;
            MLT_X100: return 100;
            default:  return 100000;
        endcase
    endfunction

endpackage

// File: rtl/pulse_width_timer.sv
// Load / decrement / zero-detect counter that times the light pulse width.
//   clk_PulseSeq : system clock
//   rst_PulseSeq : synchronous active-high reset
//   load         : load load_val (takes priority over dec)
//   load_val     : value to load
//   dec          : decrement by one, holding at zero
//   zero         : counter is zero
module pulse_width_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk_PulseSeq,
    input  logic             rst_PulseSeq,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk_PulseSeq) begin
        if (rst_PulseSeq) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pulse_sequencer.sv
// Burst controller: handshakes with the delay generator and emits N light
// pulses of programmable width per burst.
//   clk_PulseSeq/rst_PulseSeq : clock, synchronous active-high reset
//   start, abort              : burst request (IDLE only), early termination
//   n_pulses, pulse_width,
//   delay, dl_mlt             : burst configuration, latched on accepted start
//   end_flg                   : delay-expired flag from the delay generator
//   dl_launch, delay_o,
//   dl_mlt_o                  : request and latched settings to the delay generator
//   light_pulse               : light pulse output
//   busy, done, aborted       : status; done is a one-cycle end-of-burst strobe
//   pulse_cnt                 : pulses emitted in the current or last burst
// All outputs are registered; they are computed from the next state.
module pulse_sequencer
    import pulse_seq_pkg::*;
#(
    parameter int CNT_W = 16,
    parameter int N_W   = 8
) (
    input  logic             clk_PulseSeq,
    input  logic             rst_PulseSeq,
    input  logic             start,
    input  logic             abort,
    input  logic [N_W-1:0]   n_pulses,
    input  logic [CNT_W-1:0] pulse_width,
    input  logic [16:0]      delay,
    input  logic [4:0]       dl_mlt,
    input  logic             end_flg,
    output logic             dl_launch,
    output logic [16:0]      delay_o,
    output logic [4:0]       dl_mlt_o,
    output logic             light_pulse,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [N_W-1:0]   pulse_cnt
);

    state_t           state, state_nxt;
    logic [N_W-1:0]   n_lat, n_nxt;
    logic [CNT_W-1:0] pw_lat, pw_nxt;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_load, tmr_dec, tmr_zero;

    logic             dl_launch_nxt, light_nxt, busy_nxt, done_nxt, aborted_nxt;
    logic [16:0]      delay_nxt;
    logic [4:0]       mlt_nxt;
    logic [N_W-1:0]   cnt_nxt;

    // A width of 0 behaves as 1: the counter holds the remaining cycles after
    // the first one, so it loads max(width,1)-1.
    assign tmr_load_val = (pw_lat == '0) ? '0 : pw_lat - 1'b1;

    pulse_width_timer #(.CNT_W(CNT_W)) u_timer (
        .clk_PulseSeq (clk_PulseSeq),
        .rst_PulseSeq (rst_PulseSeq),
        .load         (tmr_load),
        .load_val     (tmr_load_val),
        .dec          (tmr_dec),
        .zero         (tmr_zero)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_nxt     = state;
        n_nxt         = n_lat;
        pw_nxt        = pw_lat;
        delay_nxt     = delay_o;
        mlt_nxt       = dl_mlt_o;
        cnt_nxt       = pulse_cnt;
        aborted_nxt   = aborted;
        dl_launch_nxt = 1'b0;
        light_nxt     = 1'b0;
        tmr_load      = 1'b0;
        tmr_dec       = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    n_nxt       = n_pulses;
                    pw_nxt      = pulse_width;
                    delay_nxt   = delay;
                    mlt_nxt     = dl_mlt;
                    cnt_nxt     = '0;
                    aborted_nxt = 1'b0;
                    if (n_pulses == '0) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt     = LAUNCH;
                        dl_launch_nxt = 1'b1;
                    end
                end
            end
            LAUNCH: begin
                // abort wins over a simultaneous end_flg: no pulse is fired.
                if (abort) begin
                    state_nxt   = RECOVER;
                    aborted_nxt = 1'b1;
                end else if (end_flg) begin
                    state_nxt = PULSE;
                    light_nxt = 1'b1;
                    tmr_load  = 1'b1;
                    cnt_nxt   = pulse_cnt + 1'b1;
                end else begin
                    dl_launch_nxt = 1'b1;
                end
            end
            PULSE: begin
                if (abort) begin
                    state_nxt   = RECOVER;
                    aborted_nxt = 1'b1;
                end else if (tmr_zero) begin
                    state_nxt = RECOVER;
                end else begin
                    light_nxt = 1'b1;
                    tmr_dec   = 1'b1;
                end
            end
            RECOVER: begin
                // Wait for the delay generator to clear before relaunching.
                if (!end_flg) begin
                    if (aborted || (pulse_cnt == n_lat)) begin
                        state_nxt = DONE;
                    end else begin
                        state_nxt     = LAUNCH;
                        dl_launch_nxt = 1'b1;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = state_nxt inside {LAUNCH, PULSE, RECOVER};
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clk_PulseSeq) begin
        if (rst_PulseSeq) begin
            state       <= IDLE;
            n_lat       <= '0;
            pw_lat      <= '0;
            delay_o     <= '0;
            dl_mlt_o    <= '0;
            pulse_cnt   <= '0;
            aborted     <= 1'b0;
            dl_launch   <= 1'b0;
            light_pulse <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            n_lat       <= n_nxt;
            pw_lat      <= pw_nxt;
            delay_o     <= delay_nxt;
            dl_mlt_o    <= mlt_nxt;
            pulse_cnt   <= cnt_nxt;
            aborted     <= aborted_nxt;
            dl_launch   <= dl_launch_nxt;
            light_pulse <= light_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed self-checking bench for pulse_sequencer with a behavioural delay
// generator: end_flg rises after delay_o*factor clocks of dl_launch and clears
// one clock after dl_launch falls.
module tb_pulse_sequencer;
    import pulse_seq_pkg::*;

    localparam int CNT_W = 16;
    localparam int N_W   = 8;

    logic             clk_PulseSeq = 1'b0;
    logic             rst_PulseSeq = 1'b1;
    logic             start        = 1'b0;
    logic             abort        = 1'b0;
    logic [N_W-1:0]   n_pulses     = '0;
    logic [CNT_W-1:0] pulse_width  = '0;
    logic [16:0]      delay        = '0;
    logic [4:0]       dl_mlt       = '0;
    logic             end_flg      = 1'b0;
    logic             dl_launch;
    logic [16:0]      delay_o;
    logic [4:0]       dl_mlt_o;
    logic             light_pulse;
    logic             busy;
    logic             done;
    logic             aborted;
    logic [N_W-1:0]   pulse_cnt;

    int checks   = 0;
    int failures = 0;

    pulse_sequencer #(.CNT_W(CNT_W), .N_W(N_W)) dut (
        .clk_PulseSeq (clk_PulseSeq),
        .rst_PulseSeq (rst_PulseSeq),
        .start        (start),
        .abort        (abort),
        .n_pulses     (n_pulses),
        .pulse_width  (pulse_width),
        .delay        (delay),
        .dl_mlt       (dl_mlt),
        .end_flg      (end_flg),
        .dl_launch    (dl_launch),
        .delay_o      (delay_o),
        .dl_mlt_o     (dl_mlt_o),
        .light_pulse  (light_pulse),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .pulse_cnt    (pulse_cnt)
    );

    always #5 clk_PulseSeq = ~clk_PulseSeq;

    // Delay generator model.
    int unsigned dcnt = 0;
    always @(posedge clk_PulseSeq) begin
        if (rst_PulseSeq || !dl_launch) begin
            dcnt    <= 0;
            end_flg <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
            if (dcnt + 1 >= int'(delay_o) * mlt_factor(dl_mlt_o)) end_flg <= 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive a one-cycle start; returns at the falling edge after the accepting edge.
    task automatic do_start(input int n, input int pw, input int dly, input logic [4:0] mlt);
        @(negedge clk_PulseSeq);
        n_pulses    = N_W'(n);
        pulse_width = CNT_W'(pw);
        delay       = 17'(dly);
        dl_mlt      = mlt;
        start       = 1'b1;
        @(negedge clk_PulseSeq);
        start = 1'b0;
    endtask

    // Watch the burst until done, measuring pulses that start inside the window.
    task automatic run_to_done(input string tag, input int budget, output int np,
                               output int wmin, output int wmax,
                               output bit overlap, output bit excl_err);
        int run;
        bit prev_lp;
        bit got;
        np = 0; wmin = 2147483647; wmax = 0; overlap = 0; excl_err = 0;
        run = 0; prev_lp = light_pulse; got = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk_PulseSeq);
            if (light_pulse && dl_launch) overlap = 1;
            if (busy && done) excl_err = 1;
            if (light_pulse) begin
                if (!prev_lp) np++;
                run++;
            end else if (prev_lp) begin
                if (run < wmin) wmin = run;
                if (run > wmax) wmax = run;
                run = 0;
            end
            prev_lp = light_pulse;
            if (done) got = 1;
        end
        check({tag, "_done_seen"}, 32'(got), 1);
    endtask

    initial begin
        int  np, wmin, wmax, rises;
        bit  ov, ex, seen, prev;

        // Reset state
        repeat (2) @(negedge clk_PulseSeq);
        check("rst_light", 32'(light_pulse), 0);
        check("rst_launch", 32'(dl_launch), 0);
        check("rst_busy_done", {30'd0, busy, done}, 0);
        check("rst_aborted", 32'(aborted), 0);
        check("rst_cnt", 32'(pulse_cnt), 0);
        check("rst_delay_o", 32'(delay_o), 0);
        check("rst_mlt_o", 32'(dl_mlt_o), 0);
        rst_PulseSeq = 1'b0;

        // T1: 3 pulses of width 5, delay 10 x1
        do_start(3, 5, 10, MLT_X1);
        check("t1_busy", 32'(busy), 1);
        check("t1_launch", 32'(dl_launch), 1);
        check("t1_delay_o", 32'(delay_o), 10);
        check("t1_mlt_o", 32'(dl_mlt_o), 1);
        run_to_done("t1", 2000, np, wmin, wmax, ov, ex);
        check("t1_npulses", 32'(np), 3);
        check("t1_wmin", 32'(wmin), 5);
        check("t1_wmax", 32'(wmax), 5);
        check("t1_overlap", 32'(ov), 0);
        check("t1_busy_done_excl", 32'(ex), 0);
        check("t1_cnt", 32'(pulse_cnt), 3);
        check("t1_aborted", 32'(aborted), 0);
        check("t1_busy_at_done", 32'(busy), 0);
        @(negedge clk_PulseSeq);
        check("t1_done_one_cycle", 32'(done), 0);

        // T2: zero pulses -> straight to DONE
        do_start(0, 5, 10, MLT_X1);
        check("t2_done", 32'(done), 1);
        check("t2_busy", 32'(busy), 0);
        check("t2_launch", 32'(dl_launch), 0);
        check("t2_light", 32'(light_pulse), 0);
        check("t2_cnt", 32'(pulse_cnt), 0);
        @(negedge clk_PulseSeq);
        check("t2_done_one_cycle", 32'(done), 0);
        check("t2_launch_after", 32'(dl_launch), 0);

        // T3: width 0 behaves as 1; end_flg -> pulse timing
        do_start(1, 0, 3, MLT_X1);
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk_PulseSeq);
            if (end_flg) seen = 1;
        end
        check("t3_end_flg_seen", 32'(seen), 1);
        @(negedge clk_PulseSeq);
        check("t3_light_on", 32'(light_pulse), 1);
        check("t3_launch_off", 32'(dl_launch), 0);
        check("t3_cnt", 32'(pulse_cnt), 1);
        @(negedge clk_PulseSeq);
        check("t3_light_off", 32'(light_pulse), 0);
        run_to_done("t3", 100, np, wmin, wmax, ov, ex);
        check("t3_cnt_end", 32'(pulse_cnt), 1);
        check("t3_aborted", 32'(aborted), 0);

        // T4: abort during 2nd pulse of a 4-pulse burst
        do_start(4, 8, 4, MLT_X1);
        rises = 0; prev = light_pulse; seen = 0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge clk_PulseSeq);
            if (light_pulse && !prev) rises++;
            prev = light_pulse;
            if (rises == 2 && light_pulse) seen = 1;
        end
        check("t4_second_pulse_seen", 32'(seen), 1);
        abort = 1'b1;
        @(negedge clk_PulseSeq);
        abort = 1'b0;
        check("t4_light_off", 32'(light_pulse), 0);
        check("t4_launch_off", 32'(dl_launch), 0);
        check("t4_aborted", 32'(aborted), 1);
        check("t4_busy", 32'(busy), 1);
        run_to_done("t4", 100, np, wmin, wmax, ov, ex);
        check("t4_no_more_pulses", 32'(np), 0);
        check("t4_aborted_at_done", 32'(aborted), 1);
        check("t4_cnt", 32'(pulse_cnt), 2);

        // T5: start while busy and delay change mid-burst are ignored
        do_start(2, 3, 10, MLT_X1);
        repeat (2) @(negedge clk_PulseSeq);
        delay = 17'd20;
        start = 1'b1;
        @(negedge clk_PulseSeq);
        start = 1'b0;
        check("t5_delay_o_held", 32'(delay_o), 10);
        check("t5_busy", 32'(busy), 1);
        check("t5_aborted_clear", 32'(aborted), 0);
        run_to_done("t5", 2000, np, wmin, wmax, ov, ex);
        check("t5_npulses", 32'(np), 2);
        check("t5_cnt", 32'(pulse_cnt), 2);
        check("t5_delay_o_end", 32'(delay_o), 10);
        do_start(1, 2, 20, MLT_X1);
        check("t5_delay_o_new", 32'(delay_o), 20);
        run_to_done("t5b", 2000, np, wmin, wmax, ov, ex);
        check("t5b_npulses", 32'(np), 1);
        check("t5b_width", 32'(wmax), 2);

        // T6: reset mid-pulse, then a fresh x100 burst
        do_start(2, 6, 5, MLT_X1);
        seen = 0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk_PulseSeq);
            if (light_pulse) seen = 1;
        end
        check("t6_pulse_seen", 32'(seen), 1);
        rst_PulseSeq = 1'b1;
        @(negedge clk_PulseSeq);
        rst_PulseSeq = 1'b0;
        check("t6_light", 32'(light_pulse), 0);
        check("t6_launch", 32'(dl_launch), 0);
        check("t6_busy_done", {30'd0, busy, done}, 0);
        check("t6_cnt", 32'(pulse_cnt), 0);
        check("t6_delay_o", 32'(delay_o), 0);
        check("t6_mlt_o", 32'(dl_mlt_o), 0);
        do_start(2, 4, 1, MLT_X100);
        check("t6_mlt_o_new", 32'(dl_mlt_o), 2);
        check("t6_busy_new", 32'(busy), 1);
        run_to_done("t6", 2000, np, wmin, wmax, ov, ex);
        check("t6_npulses", 32'(np), 2);
        check("t6_wmin", 32'(wmin), 4);
        check("t6_wmax", 32'(wmax), 4);
        check("t6_overlap", 32'(ov), 0);
        check("t6_cnt_end", 32'(pulse_cnt), 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
